// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART command scheduler.
//   sched_state_t : scheduler FSM states
//   cmd_t         : 16-bit command split into opcode / operand
//   RESP_*        : response bytes sent back over the wrapper TX
package uart_sched_pkg;
  localparam int OPC_W = 4;
  localparam int ARG_W = 12;

  localparam logic [7:0] RESP_ACK     = 8'hA5;
  localparam logic [7:0] RESP_NAK_TO  = 8'hEE;
  localparam logic [7:0] RESP_NAK_ILL = 8'hEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_RESP,
    S_TXWAIT
  } sched_state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [ARG_W-1:0] arg;
  } cmd_t;
endpackage

// File: rtl/cmd_timeout_cnt.sv
// Saturating TO_W-bit timeout counter for the scheduler WAIT state.
//   clk, rst : clock, async active-high reset
//   clr      : zero the counter
//   en       : count one cycle
//   expired  : high in the enabled cycle whose increment reaches 2**TO_W-1
//              (or when already saturated)
module cmd_timeout_cnt #(
  parameter int TO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TO_W-1:0] MAX = '1;

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != MAX)  cnt <= cnt + 1'b1;
  end

  // Flag one cycle early so the owner leaves WAIT after exactly MAX cycles.
  assign expired = en && (cnt >= MAX - 1'b1);
endmodule

// File: rtl/uart_cmd_sched.sv
// Command scheduler between the UART command wrapper and execution units.
// Accepts a 16-bit command, dispatches it to the unit chosen by the opcode,
// waits for completion or timeout and sends a 1-byte ACK/NAK on the shared TX.
// Unsolicited event bytes are sent on the same TX when no command is pending.
//   clk, rst     : clock, async active-high reset
//   cmd_rdy, cmd : command from wrapper; clr_cmd_rdy consumes it
//   trmt, resp   : TX start pulse and byte; tx_done marks byte sent (edge)
//   unit_go      : one-hot start pulse; unit_arg operand; unit_done completion
//   evt_req/byte : event request and byte; evt_gnt accepts it
//   busy         : high outside IDLE
module uart_cmd_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int TO_W      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_rdy,
  input  logic [15:0]          cmd,
  output logic                 clr_cmd_rdy,
  output logic                 trmt,
  output logic [7:0]           resp,
  input  logic                 tx_done,
  output logic [NUM_UNITS-1:0] unit_go,
  output logic [ARG_W-1:0]     unit_arg,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic                 evt_req,
  input  logic [7:0]           evt_byte,
  output logic                 evt_gnt,
  output logic                 busy
);
  sched_state_t state, state_nxt;
  cmd_t         cmd_in, cmd_q;
  logic [7:0]   resp_q, resp_nxt;
  logic         resp_ld, cmd_ld;
  logic         tx_done_q, tx_edge;
  logic         tmr_clr, tmr_en, tmr_exp;
  logic         legal;
  logic [NUM_UNITS-1:0] sel_mask;

  assign cmd_in   = cmd_t'(cmd);
  assign legal    = 32'(cmd_in.opc) < NUM_UNITS;
  assign sel_mask = NUM_UNITS'(1) << cmd_q.opc;
  assign tx_edge  = tx_done & ~tx_done_q;
  assign tmr_clr  = (state == S_DISPATCH);
  assign tmr_en   = (state == S_WAIT);

  cmd_timeout_cnt #(.TO_W(TO_W)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      resp_q    <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      if (cmd_ld)  cmd_q  <= cmd_in;
      if (resp_ld) resp_q <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cmd_rdy = 1'b0;
    trmt        = 1'b0;
    evt_gnt     = 1'b0;
    unit_go     = '0;
    cmd_ld      = 1'b0;
    resp_ld     = 1'b0;
    resp_nxt    = resp_q;
    case (state)
      S_IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          cmd_ld      = 1'b1;
          if (legal) begin
            state_nxt = S_DISPATCH;
          end else begin
            resp_ld   = 1'b1;
            resp_nxt  = RESP_NAK_ILL;
            state_nxt = S_RESP;
          end
        end else if (evt_req) begin
          resp_ld   = 1'b1;
          resp_nxt  = evt_byte;
          evt_gnt   = 1'b1;
          trmt      = 1'b1;
          state_nxt = S_TXWAIT;
        end
      end
      S_DISPATCH: begin
        unit_go   = sel_mask;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats a coincident timeout.
        if (|(unit_done & sel_mask)) begin
          resp_ld   = 1'b1;
          resp_nxt  = RESP_ACK;
          state_nxt = S_RESP;
        end else if (tmr_exp) begin
          resp_ld   = 1'b1;
          resp_nxt  = RESP_NAK_TO;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        trmt      = 1'b1;
        state_nxt = S_TXWAIT;
      end
      S_TXWAIT: begin
        if (tx_edge) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // IDLE Mealy outputs would otherwise follow cmd_rdy/evt_req during reset.
    if (rst) begin
      clr_cmd_rdy = 1'b0;
      trmt        = 1'b0;
      evt_gnt     = 1'b0;
    end
  end

  assign resp     = resp_q;
  assign unit_arg = (state == S_DISPATCH || state == S_WAIT) ? cmd_q.arg : '0;
  assign busy     = (state != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_sched.sv
module tb_uart_cmd_sched;
  localparam int NU   = 4;
  localparam int TOW  = 6;
  localparam int TMO  = (1 << TOW) - 1;   // cycles spent in WAIT before timeout

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_rdy = 1'b0;
  logic [15:0]   cmd = '0;
  logic          clr_cmd_rdy, trmt, evt_gnt, busy;
  logic [7:0]    resp;
  logic          tx_done = 1'b0;
  logic [NU-1:0] unit_go;
  logic [11:0]   unit_arg;
  logic [NU-1:0] unit_done = '0;
  logic          evt_req = 1'b0;
  logic [7:0]    evt_byte = '0;

  int n_cmp = 0;
  int n_err = 0;

  uart_cmd_sched #(.NUM_UNITS(NU), .TO_W(TOW)) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
    .trmt(trmt), .resp(resp), .tx_done(tx_done), .unit_go(unit_go), .unit_arg(unit_arg),
    .unit_done(unit_done), .evt_req(evt_req), .evt_byte(evt_byte), .evt_gnt(evt_gnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a reply byte for opcode opc whose unit completes at WAIT index d.
  function automatic logic [7:0] ref_resp(input int opc, input int d);
    if (opc >= NU)      return 8'hEF;
    else if (d < TMO)   return 8'hA5;
    else                return 8'hEE;
  endfunction

  // Reference: WAIT index (0 = first WAIT cycle) at which trmt appears.
  function automatic int ref_idx(input int d);
    return (d + 1 < TMO) ? d + 1 : TMO;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // From the DISPATCH cycle, walk WAIT cycles pulsing unit_done and report
  // the index at which trmt is seen (-1 if never within the budget).
  task automatic wait_trmt(input int done_at, input logic [NU-1:0] done_mask,
                           input int bad_at, input logic [NU-1:0] bad_mask,
                           output int idx);
    idx = -1;
    for (int k = 0; k < TMO + 10; k++) begin
      step();
      unit_done = ((k == done_at) ? done_mask : '0) | ((k == bad_at) ? bad_mask : '0);
      #1;
      if (trmt) begin
        idx = k;
        break;
      end
    end
    unit_done = '0;
  endtask

  // Finish the TX phase: dly extra TXWAIT cycles, then one tx_done pulse.
  // Returns at posedge+2 of the cycle after the edge was seen.
  task automatic tx_finish(input int dly);
    step();
    repeat (dly) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    #3;
    cmd_rdy = 1'b1; cmd = 16'h1234; evt_req = 1'b1; unit_done = '1;
    #1;
    outs = {clr_cmd_rdy, trmt, resp, unit_go, unit_arg, evt_gnt, busy};
    n_cmp++;
    if (outs !== 28'h0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs); end
    step(); step();
    outs = {clr_cmd_rdy, trmt, resp, unit_go, unit_arg, evt_gnt, busy};
    n_cmp++;
    if (outs !== 28'h0) begin n_err++; $display("FAIL reset_hold: got %h want 0", outs); end
    cmd_rdy = 1'b0; evt_req = 1'b0; unit_done = '0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_ack();
    int idx;
    step();
    cmd = 16'h1234; cmd_rdy = 1'b1;
    #1;
    n_cmp++;
    if (clr_cmd_rdy !== 1'b1) begin n_err++; $display("FAIL ack_clr: got %b want 1", clr_cmd_rdy); end
    step();
    cmd_rdy = 1'b0;
    #1;
    n_cmp++;
    if (unit_go !== 4'b0010) begin n_err++; $display("FAIL ack_go: got %b want 0010", unit_go); end
    n_cmp++;
    if (unit_arg !== 12'h234) begin n_err++; $display("FAIL ack_arg: got %h want 234", unit_arg); end
    wait_trmt(0, 4'b0010, -1, '0, idx);
    n_cmp++;
    if (idx !== 1) begin n_err++; $display("FAIL ack_latency: got %0d want 1", idx); end
    n_cmp++;
    if (resp !== 8'hA5) begin n_err++; $display("FAIL ack_resp: got %h want a5", resp); end
    tx_finish(2);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL ack_busy: got %b want 0", busy); end
  endtask

  task automatic test_illegal();
    step();
    cmd = 16'h7000; cmd_rdy = 1'b1;
    #1;
    n_cmp++;
    if (clr_cmd_rdy !== 1'b1) begin n_err++; $display("FAIL ill_clr: got %b want 1", clr_cmd_rdy); end
    step();
    cmd_rdy = 1'b0;
    #1;
    n_cmp++;
    if ({unit_go, trmt, resp} !== {4'b0000, 1'b1, 8'hEF})
      begin n_err++; $display("FAIL ill_resp: go=%b trmt=%b resp=%h want go=0000 trmt=1 resp=ef", unit_go, trmt, resp); end
    tx_finish(0);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL ill_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int idx;
    step();
    cmd = 16'h2001; cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    #1;
    wait_trmt(-1, '0, -1, '0, idx);
    n_cmp++;
    if (idx !== TMO) begin n_err++; $display("FAIL to_latency: got %0d want %0d", idx, TMO); end
    n_cmp++;
    if (resp !== 8'hEE) begin n_err++; $display("FAIL to_resp: got %h want ee", resp); end
    tx_finish(1);
  endtask

  task automatic test_wrong_unit_and_coincide();
    int idx;
    step();
    cmd = 16'h2abc; cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    #1;
    // Foreign completion at index 5, own completion on the timeout cycle.
    wait_trmt(TMO - 1, 4'b0100, 5, 4'b0001, idx);
    n_cmp++;
    if (idx !== TMO) begin n_err++; $display("FAIL coin_latency: got %0d want %0d", idx, TMO); end
    n_cmp++;
    if (resp !== 8'hA5) begin n_err++; $display("FAIL coin_resp: got %h want a5", resp); end
    tx_finish(0);
  endtask

  task automatic test_event();
    step();
    evt_req = 1'b1; evt_byte = 8'h5A; tx_done = 1'b1;  // level already high at trmt
    #1;
    n_cmp++;
    if ({evt_gnt, trmt, clr_cmd_rdy} !== 3'b110)
      begin n_err++; $display("FAIL evt_gnt: got %b want 110", {evt_gnt, trmt, clr_cmd_rdy}); end
    step();
    evt_req = 1'b0;
    #1;
    n_cmp++;
    if ({resp, busy, trmt, evt_gnt} !== {8'h5A, 3'b100})
      begin n_err++; $display("FAIL evt_resp: resp=%h busy=%b trmt=%b gnt=%b want 5a 1 0 0", resp, busy, trmt, evt_gnt); end
    step();
    tx_done = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL evt_level: got busy=%b want 1", busy); end
    tx_finish(0);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL evt_busy: got %b want 0", busy); end
  endtask

  task automatic test_priority();
    int idx;
    step();
    cmd = 16'h0abc; cmd_rdy = 1'b1; evt_req = 1'b1; evt_byte = 8'hC3;
    #1;
    n_cmp++;
    if ({clr_cmd_rdy, evt_gnt, trmt} !== 3'b100)
      begin n_err++; $display("FAIL pri_idle: got %b want 100", {clr_cmd_rdy, evt_gnt, trmt}); end
    step();
    cmd_rdy = 1'b0;
    #1;
    n_cmp++;
    if ({unit_go, evt_gnt} !== {4'b0001, 1'b0})
      begin n_err++; $display("FAIL pri_go: got go=%b gnt=%b want 0001 0", unit_go, evt_gnt); end
    wait_trmt(2, 4'b0001, -1, '0, idx);
    n_cmp++;
    if ({idx == 3, resp, evt_gnt} !== {1'b1, 8'hA5, 1'b0})
      begin n_err++; $display("FAIL pri_cmd_resp: idx=%0d resp=%h gnt=%b want 3 a5 0", idx, resp, evt_gnt); end
    tx_finish(0);
    n_cmp++;
    if ({evt_gnt, trmt} !== 2'b11) begin n_err++; $display("FAIL pri_evt_gnt: got %b want 11", {evt_gnt, trmt}); end
    step();
    evt_req = 1'b0;
    #1;
    n_cmp++;
    if (resp !== 8'hC3) begin n_err++; $display("FAIL pri_evt_resp: got %h want c3", resp); end
    tx_finish(0);
  endtask

  task automatic test_back_to_back();
    int idx;
    step();
    cmd = 16'h2aaa; cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    step();
    cmd = 16'h1bbb; cmd_rdy = 1'b1; unit_done = 4'b0100;
    #1;
    n_cmp++;
    if (clr_cmd_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_clr: got %b want 0", clr_cmd_rdy); end
    step();
    unit_done = '0;
    #1;
    n_cmp++;
    if ({trmt, resp, clr_cmd_rdy} !== {1'b1, 8'hA5, 1'b0})
      begin n_err++; $display("FAIL b2b_first: trmt=%b resp=%h clr=%b want 1 a5 0", trmt, resp, clr_cmd_rdy); end
    tx_finish(1);
    n_cmp++;
    if ({busy, clr_cmd_rdy} !== 2'b01) begin n_err++; $display("FAIL b2b_accept: got %b want 01", {busy, clr_cmd_rdy}); end
    step();
    cmd_rdy = 1'b0;
    #1;
    n_cmp++;
    if ({unit_go, unit_arg} !== {4'b0010, 12'hBBB})
      begin n_err++; $display("FAIL b2b_go: go=%b arg=%h want 0010 bbb", unit_go, unit_arg); end
    wait_trmt(3, 4'b0010, -1, '0, idx);
    n_cmp++;
    if (idx !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d want 4", idx); end
    tx_finish(0);
  endtask

  task automatic test_reset_mid();
    logic [27:0] outs;
    int idx;
    step();
    cmd = 16'h3111; cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    step(); step();
    // In WAIT: reset while a new command is already pending.
    rst = 1'b1; cmd = 16'h2055; cmd_rdy = 1'b1; evt_req = 1'b1;
    #1;
    outs = {clr_cmd_rdy, trmt, resp, unit_go, unit_arg, evt_gnt, busy};
    n_cmp++;
    if (outs !== 28'h0) begin n_err++; $display("FAIL rstmid_outs: got %h want 0", outs); end
    step();
    rst = 1'b0; evt_req = 1'b0;
    #1;
    n_cmp++;
    if ({clr_cmd_rdy, resp} !== {1'b1, 8'h00})
      begin n_err++; $display("FAIL rstmid_accept: clr=%b resp=%h want 1 00", clr_cmd_rdy, resp); end
    step();
    cmd_rdy = 1'b0;
    #1;
    n_cmp++;
    if ({unit_go, unit_arg} !== {4'b0100, 12'h055})
      begin n_err++; $display("FAIL rstmid_go: go=%b arg=%h want 0100 055", unit_go, unit_arg); end
    wait_trmt(0, 4'b0100, -1, '0, idx);
    n_cmp++;
    if ({idx == 1, resp} !== {1'b1, 8'hA5})
      begin n_err++; $display("FAIL rstmid_resp: idx=%0d resp=%h want 1 a5", idx, resp); end
    tx_finish(0);
  endtask

  task automatic test_random();
    int opc, d, bad_at, idx, dly;
    logic [11:0] arg;
    logic [NU-1:0] mask, bad;
    for (int it = 0; it < 40; it++) begin
      opc    = $urandom_range(0, 7);
      arg    = 12'($urandom);
      d      = $urandom_range(0, TMO + 6);
      bad_at = $urandom_range(0, TMO + 6);
      dly    = $urandom_range(0, 3);
      mask   = (opc < NU) ? NU'(1) << opc : '0;
      bad    = NU'(1) << ((opc + 1) % NU);
      step();
      cmd = {4'(opc), arg}; cmd_rdy = 1'b1;
      #1;
      n_cmp++;
      if (clr_cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rnd_clr it%0d: got %b want 1", it, clr_cmd_rdy); end
      step();
      cmd_rdy = 1'b0;
      #1;
      if (opc >= NU) begin
        n_cmp++;
        if ({unit_go, trmt, resp} !== {4'b0000, 1'b1, ref_resp(opc, d)})
          begin n_err++; $display("FAIL rnd_ill it%0d: go=%b trmt=%b resp=%h want 0000 1 ef", it, unit_go, trmt, resp); end
      end else begin
        n_cmp++;
        if ({unit_go, unit_arg} !== {mask, arg})
          begin n_err++; $display("FAIL rnd_go it%0d: go=%b arg=%h want %b %h", it, unit_go, unit_arg, mask, arg); end
        wait_trmt(d, mask, bad_at, bad, idx);
        n_cmp++;
        if (idx !== ref_idx(d)) begin n_err++; $display("FAIL rnd_idx it%0d: got %0d want %0d", it, idx, ref_idx(d)); end
        n_cmp++;
        if (resp !== ref_resp(opc, d))
          begin n_err++; $display("FAIL rnd_resp it%0d: got %h want %h", it, resp, ref_resp(opc, d)); end
      end
      tx_finish(dly);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_busy it%0d: got %b want 0", it, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_illegal();
    test_timeout();
    test_wrong_unit_and_coincide();
    test_event();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
